// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared widths, constants and the fetch-entry type used by the
//             instruction fetch stage and its skid FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // One fetched instruction paired with the PC it was fetched for.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               misaligned;
  } fetch_entry_t;

  // Word-aligned version of a byte address.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_skid_fifo
//  Purpose  : Two-entry synchronous skid FIFO holding fetched instructions.
//             Entry 0 is always the head; entry 1 is the overflow slot.
//             flush wins over push; a pop in the flush cycle still completes
//             (the consumer already took the head).
//  Ports    : clka         - clock
//             rst          - asynchronous active-high reset
//             push_i       - write push_data_i at the edge
//             push_data_i  - entry to write
//             pop_i        - head consumed this cycle
//             flush_i      - discard all entries
//             count_o      - current occupancy
//             head_o       - head entry (reset value while nothing was ever pushed)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int           FIFO_DEPTH  = 2,   // only 2 is supported
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic                               clka,
  input  logic                               rst,
  input  logic                               push_i,
  input  fetch_entry_t                       push_data_i,
  input  logic                               pop_i,
  input  logic                               flush_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
  output fetch_entry_t                       head_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_entry_t     entry0_q, entry0_d;
  fetch_entry_t     entry1_q, entry1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_pop;

  // Ignore a pop against an empty FIFO rather than underflowing the count.
  assign w_pop = pop_i & (count_q != CNT_W'(0));

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_i, w_pop})
        2'b10: begin
          if (count_q == CNT_W'(0)) entry0_d = push_data_i;
          else                      entry1_d = push_data_i;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          entry0_d = entry1_q;
          count_d  = count_q - CNT_W'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count_q == CNT_W'(1)) begin
            entry0_d = push_data_i;
          end else begin
            entry0_d = entry1_q;
            entry1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      entry0_q <= RESET_ENTRY;
      entry1_q <= '0;
      count_q  <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Instruction fetch stage. Owns the PC, drives a 1-cycle
//             synchronous instruction BRAM, pairs returned words with their
//             PC and hands them to decode through a 2-entry skid FIFO.
//             Redirects flush everything and restart fetch at the target.
//  Ports    : clka           - clock
//             rst            - asynchronous active-high reset
//             rom_addr       - registered byte address to BRAM
//             rom_data       - BRAM read data for the previously sampled address
//             redirect_valid - branch/jump taken this cycle
//             redirect_pc    - redirect target (may be misaligned)
//             id_valid       - instruction available to decode
//             id_ready       - decode accepts this cycle
//             id_instr       - instruction word
//             id_pc          - PC of id_instr
//             id_misaligned  - id_pc[1:0] != 0
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2              // only 2 is supported
) (
  input  logic               clka,
  input  logic               rst,
  output logic [31:0]        rom_addr,
  input  logic [31:0]        rom_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic               id_misaligned
);

  localparam int           CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int           OCC_W       = CNT_W + 1;
  localparam fetch_entry_t RESET_ENTRY = '{instr: NOP_INSTR, pc: RESET_PC, misaligned: 1'b0};

  logic [31:0]      rom_addr_q, rom_addr_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  // Low PC bits of the last redirect target; they ride along with the first
  // fetch after the redirect so that word reports the full target PC.
  logic [1:0]       pend_lo_q, pend_lo_d;

  logic [CNT_W-1:0] w_count;
  logic [OCC_W-1:0] w_occ;
  logic             w_pop;
  logic             w_issue;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  assign w_pop   = id_valid & id_ready;
  // Slots that will be committed after this edge if nothing new is issued;
  // issuing only when this is below the depth guarantees no overflow.
  assign w_occ   = {1'b0, w_count} + OCC_W'(inflight_q) - OCC_W'(w_pop);
  assign w_issue = ~redirect_valid & (w_occ < OCC_W'(FIFO_DEPTH));

  always_comb begin
    rom_addr_d    = rom_addr_q;
    inflight_d    = w_issue;
    inflight_pc_d = inflight_pc_q;
    pend_lo_d     = pend_lo_q;
    if (redirect_valid) begin
      rom_addr_d = align_pc(redirect_pc);
      pend_lo_d  = redirect_pc[1:0];
    end else if (w_issue) begin
      rom_addr_d    = rom_addr_q + PC_INCR;
      inflight_pc_d = {rom_addr_q[31:2], pend_lo_q};
      pend_lo_d     = 2'b00;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rom_addr_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      pend_lo_q     <= 2'b00;
    end else begin
      rom_addr_q    <= rom_addr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      pend_lo_q     <= pend_lo_d;
    end
  end

  // Only the first word after a redirect can carry non-zero low PC bits.
  assign w_push_entry = '{instr: rom_data, pc: inflight_pc_q, misaligned: |inflight_pc_q[1:0]};

  // A word returning in a redirect cycle is dropped by the flush priority.
  fetch_skid_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_skid (
    .clka        (clka),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (redirect_valid),
    .count_o     (w_count),
    .head_o      (w_head)
  );

  assign rom_addr      = rom_addr_q;
  assign id_valid      = (w_count != CNT_W'(0));
  assign id_instr      = w_head.instr;
  assign id_pc         = w_head.pc;
  assign id_misaligned = w_head.misaligned;

endmodule
`default_nettype wire
